// File: rtl/rr_mux8_arbiter_pkg.sv
// rr_mux8_arbiter_pkg: shared constants and round-robin helpers for the arbiter slice.
package rr_mux8_arbiter_pkg;
  localparam int N_SRC = 8;
  localparam int W = 16;
  localparam int SEL_W = 3;
  function automatic logic [N_SRC-1:0] onehot3to8(input logic [SEL_W-1:0] s);
    return N_SRC'(1) << s;
  endfunction
  // Returns {any, win}; scanning from the far end lets the nearest requester overwrite.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_SRC-1:0] req, input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W:0] r;
    r = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_mux8_arbiter_mux.sv
// Mux8Way16: 16-bit, 8-way word selector used as the shared datapath.
module Mux8Way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);
  logic [15:0] w_arr [8];
  assign w_arr = '{a, b, c, d, e, f, g, h};
  assign out = w_arr[sel];
endmodule

// File: rtl/rr_mux8_arbiter_pick.sv
// rr_pick8: combinational round-robin pick of the first requester at or after ptr.
module rr_pick8
  import rr_mux8_arbiter_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);
  assign {any, win} = rr_pick(req, ptr);
endmodule

// File: rtl/rr_mux8_arbiter.sv
// rr_mux8_arbiter: round-robin sharing of one 8-way 16-bit mux with a registered valid/ready output.
module rr_mux8_arbiter
  import rr_mux8_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic [W-1:0]     i0,
  input  logic [W-1:0]     i1,
  input  logic [W-1:0]     i2,
  input  logic [W-1:0]     i3,
  input  logic [W-1:0]     i4,
  input  logic [W-1:0]     i5,
  input  logic [W-1:0]     i6,
  input  logic [W-1:0]     i7,
  output logic [N_SRC-1:0] gnt,
  output logic [W-1:0]     out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] src,
  output logic [W-1:0]     count
);
  logic [SEL_W-1:0] r_ptr, r_src, w_win;
  logic [W-1:0]     r_out, r_count, w_mux;
  logic             r_valid, w_any, w_cap, w_acc;
  rr_pick8 u_pick (.req(req), .ptr(r_ptr), .win(w_win), .any(w_any));
  Mux8Way16 u_mux (
    .a(i0), .b(i1), .c(i2), .d(i3), .e(i4), .f(i5), .g(i6), .h(i7),
    .sel(w_win), .out(w_mux)
  );
  // Out_valid doubles as the IDLE/FULL state; a capture needs an empty or draining slot.
  assign w_acc = r_valid & out_ready;
  assign w_cap = !reset & w_any & (!r_valid | out_ready);
  assign gnt = w_cap ? onehot3to8(w_win) : '0;
  assign out = r_out;
  assign out_valid = r_valid;
  assign src = r_src;
  assign count = r_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      if (w_acc) r_count <= r_count + W'(1);
      if (w_cap) begin
        r_out   <= w_mux;
        r_src   <= w_win;
        r_valid <= 1'b1;
        r_ptr   <= w_win + SEL_W'(1);
      end else if (w_acc) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// tb_rr_mux8_arbiter: scenario tasks checking the arbiter against a behavioural model.
module tb_rr_mux8_arbiter;
  logic        clk = 0, reset = 0, out_ready = 0;
  logic [7:0]  req = 0, gnt;
  logic [15:0] data [8];
  logic [15:0] out, count;
  logic        out_valid;
  logic [2:0]  src;
  int n_checks = 0, n_fail = 0;
  int m_ptr, m_src, m_valid;
  logic [15:0] m_out, m_cnt;
  logic [7:0]  exp_gnt, obs_gnt;

  always #5 clk = ~clk;

  rr_mux8_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .i0(data[0]), .i1(data[1]), .i2(data[2]), .i3(data[3]),
    .i4(data[4]), .i5(data[5]), .i6(data[6]), .i7(data[7]),
    .gnt(gnt), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .src(src), .count(count)
  );

  // Advance one clock: record gnt seen before the edge and update the model by the cycle rules.
  task automatic tick();
    int win;
    bit acc;
    #1;
    obs_gnt = gnt;
    exp_gnt = 0;
    win = -1;
    for (int i = 7; i >= 0; i--) if (req[(m_ptr + i) % 8]) win = (m_ptr + i) % 8;
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_src = 0; m_valid = 0; m_out = 0; m_cnt = 0;
    end else begin
      acc = (m_valid == 1) && out_ready;
      if (acc) m_cnt = m_cnt + 16'd1;
      if (win >= 0 && (m_valid == 0 || out_ready)) begin
        exp_gnt = 8'd1 << win;
        m_out = data[win]; m_src = win; m_valid = 1; m_ptr = (win + 1) % 8;
      end else if (acc) m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; req = 0; out_ready = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || obs_gnt !== 8'h00 || out !== 16'h0000 || count !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: valid=%b gnt=%h out=%h count=%h, want 0/00/0000/0000", c, out_valid, obs_gnt, out, count);
      end
    end
  endtask

  task automatic test_single();
    req = 8'h01; data[0] = 16'hBEEF; out_ready = 1;
    tick();
    n_checks++;
    if (obs_gnt !== 8'h01 || out !== 16'hBEEF || src !== 3'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_capture: gnt=%h out=%h src=%0d valid=%b, want 01/BEEF/0/1", obs_gnt, out, src, out_valid);
    end
    req = 0;
    tick();
    n_checks++;
    if (obs_gnt !== 8'h00 || count !== 16'd1 || out_valid !== 1'b0 || out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL single_drain: gnt=%h count=%h valid=%b out=%h, want 00/0001/0/BEEF", obs_gnt, count, out_valid, out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 8; k++) data[k] = 16'h1000 + 16'(k);
    req = 8'hFF; out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (src !== 3'(c % 8) || out !== 16'h1000 + 16'(c % 8) || obs_gnt !== 8'd1 << (c % 8) || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b cyc%0d: src=%0d out=%h gnt=%h valid=%b, want src=%0d", c, src, out, obs_gnt, out_valid, c % 8);
      end
    end
    n_checks++;
    if (count !== 16'd9) begin
      n_fail++;
      $display("FAIL b2b_count: count=%0d want 9", count);
    end
    req = 0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    data[2] = 16'h2222; data[7] = 16'h7777;
    req = 8'h84; out_ready = 0;
    tick();
    req = 8'h80;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (obs_gnt !== 8'h00 || src !== 3'd2 || out !== 16'h2222 || out_valid !== 1'b1 || count !== 16'd0) begin
        n_fail++;
        $display("FAIL stall cyc%0d: gnt=%h src=%0d out=%h valid=%b count=%0d, want 00/2/2222/1/0", c, obs_gnt, src, out, out_valid, count);
      end
    end
    out_ready = 1;
    tick();
    n_checks++;
    if (obs_gnt !== 8'h80 || src !== 3'd7 || out !== 16'h7777 || count !== 16'd1) begin
      n_fail++;
      $display("FAIL stall_release: gnt=%h src=%0d out=%h count=%0d, want 80/7/7777/1", obs_gnt, src, out, count);
    end
    req = 0;
    tick();
  endtask

  task automatic test_ptr_order();
    do_reset();
    out_ready = 1;
    req = 8'h10;
    tick();
    req = 8'h21;
    tick();
    n_checks++;
    if (obs_gnt !== 8'h20 || src !== 3'd5) begin
      n_fail++;
      $display("FAIL ptr5_first: gnt=%h src=%0d, want 20/5", obs_gnt, src);
    end
    req = 8'h01;
    tick();
    n_checks++;
    if (obs_gnt !== 8'h01 || src !== 3'd0) begin
      n_fail++;
      $display("FAIL ptr5_then0: gnt=%h src=%0d, want 01/0", obs_gnt, src);
    end
    req = 0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = 0;
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < 8; k++) data[k] = 16'($urandom);
      tick();
      n_checks++;
      if (obs_gnt !== exp_gnt || out_valid !== m_valid[0] || src !== 3'(m_src) || count !== m_cnt || (m_valid != 0 && out !== m_out)) begin
        n_fail++;
        $display("FAIL random cyc%0d: gnt=%h/%h valid=%b/%0d src=%0d/%0d count=%h/%h out=%h/%h", c, obs_gnt, exp_gnt, out_valid, m_valid, src, m_src, count, m_cnt, out, m_out);
      end
    end
    reset = 0;
  endtask

  task automatic test_count_wrap();
    int bad = 0;
    do_reset();
    req = 8'h01; out_ready = 1;
    for (int c = 0; c < 65536; c++) begin
      tick();
      if (count !== m_cnt) bad++;
    end
    n_checks++;
    if (count !== 16'hFFFF || bad != 0) begin
      n_fail++;
      $display("FAIL count_preload: count=%h want FFFF (model diffs=%0d)", count, bad);
    end
    tick();
    n_checks++;
    if (count !== 16'h0000) begin
      n_fail++;
      $display("FAIL count_wrap: count=%h want 0000", count);
    end
    req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1; req = 8'h08;
    tick();
    out_ready = 0; req = 8'h10;
    tick();
    reset = 1;
    tick();
    n_checks++;
    if (obs_gnt !== 8'h00 || out_valid !== 1'b0 || count !== 16'd0 || out !== 16'd0 || src !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid: gnt=%h valid=%b count=%h out=%h src=%0d, want 00/0/0000/0000/0", obs_gnt, out_valid, count, out, src);
    end
    reset = 0; req = 8'h81;
    tick();
    n_checks++;
    if (obs_gnt !== 8'h01 || src !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ptr: gnt=%h src=%0d, want 01/0", obs_gnt, src);
    end
    req = 0;
    tick();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) data[k] = 0;
    m_ptr = 0; m_src = 0; m_valid = 0; m_out = 0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_ptr_order();
    test_random();
    test_count_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
